// File: rtl/sregs_pkg.sv
// sregs_pkg: the special-register map shared by the read-side responder
// (sregs_rd) and the write-side block. Both ends import it, so a selector
// value means the same register on both sides.
//   CNT_W        performance counter width (two 16-bit halves)
//   SR_W         special-register data width
//   CPU_ID_DEF   default identification constant returned at SR_ID
//   sr_rd_sel_e  readable selectors
//   SR_WR_*      selectors decoded by the write-side block
package sregs_pkg;

  localparam int CNT_W = 32;
  localparam int SR_W  = 16;

  localparam logic [SR_W-1:0] CPU_ID_DEF = 16'h0001;

  typedef enum logic [SR_W-1:0] {
    SR_ID     = 16'd0,
    SR_MODE   = 16'd1,
    SR_CYC_LO = 16'd2,
    SR_CYC_HI = 16'd3,
    SR_RET_LO = 16'd4,
    SR_RET_HI = 16'd5
  } sr_rd_sel_e;

  // Write-side map: the mode register is written at the same index it is
  // read back from ({instr_mem_over, boot_mode} in bits [1:0]).
  localparam logic [SR_W-1:0] SR_WR_MODE = 16'd1;
  localparam int              SR_WR_BOOT_MODE_BIT = 0;
  localparam int              SR_WR_IMEM_OVER_BIT = 1;

endpackage

// File: rtl/snap_cnt32.sv
// snap_cnt32: 32-bit free-running event counter with a high-half snapshot.
// Software reads the low half first; that same read (snap) captures the
// high half into hi_shadow, so a later high-half read pairs coherently with
// the low half even if a 16-bit carry occurs in between.
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         count enable for this edge (+1, silent wrap)
//   snap        load hi_shadow with the pre-increment high half
//   lo          live low half of the counter
//   hi_shadow   high half captured by the most recent snap
module snap_cnt32
  import sregs_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            snap,
  output logic [SR_W-1:0] lo,
  output logic [SR_W-1:0] hi_shadow
);

  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments here mean hi_shadow samples cnt as it was
  // before this edge's increment -- exactly the coherence the snapshot needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hi_shadow <= '0;
    end else begin
      if (inc)  cnt       <= cnt + CNT_W'(1);
      if (snap) hi_shadow <= cnt[CNT_W-1:SR_W];
    end
  end

  assign lo = cnt[SR_W-1:0];

endmodule

// File: rtl/sregs_rd.sv
// sregs_rd: read-side responder for the special-register interface.
// A read strobe sampled at a clock edge returns the selected register on
// sr_out at that edge with a one-cycle sr_valid pulse; unmapped selectors
// return zero with sr_err. Owns the cycle and retired-instruction counters.
//   clk, rst_n      clock, asynchronous active-low reset
//   sr_re           read strobe, one cycle per read
//   sr_sel          register index
//   boot_mode       live boot mode from the write-side block
//   instr_mem_over  live instruction-memory override from the write-side block
//   instr_retire    one pulse per retired instruction
//   cnt_en          counter enable; both counters hold when low
//   sr_out          read data, holds between reads
//   sr_valid        read data valid pulse
//   sr_err          unmapped-selector pulse
module sregs_rd
  import sregs_pkg::*;
#(
  parameter logic [SR_W-1:0] CPU_ID = CPU_ID_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sr_re,
  input  logic [SR_W-1:0] sr_sel,
  input  logic            boot_mode,
  input  logic            instr_mem_over,
  input  logic            instr_retire,
  input  logic            cnt_en,
  output logic [SR_W-1:0] sr_out,
  output logic            sr_valid,
  output logic            sr_err
);

  logic [SR_W-1:0] cyc_lo, cyc_hi;
  logic [SR_W-1:0] ret_lo, ret_hi;
  logic            snap_cyc, snap_ret;
  logic [SR_W-1:0] rd_data;
  logic            rd_err;

  // A low-half read is what freezes the matching high half.
  assign snap_cyc = sr_re && (sr_sel == SR_CYC_LO);
  assign snap_ret = sr_re && (sr_sel == SR_RET_LO);

  snap_cnt32 u_cyc (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (cnt_en),
    .snap      (snap_cyc),
    .lo        (cyc_lo),
    .hi_shadow (cyc_hi)
  );

  snap_cnt32 u_ret (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (cnt_en && instr_retire),
    .snap      (snap_ret),
    .lo        (ret_lo),
    .hi_shadow (ret_hi)
  );

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (sr_sel)
      SR_ID:     rd_data = CPU_ID;
      SR_MODE:   rd_data = {14'b0, instr_mem_over, boot_mode};
      SR_CYC_LO: rd_data = cyc_lo;
      SR_CYC_HI: rd_data = cyc_hi;
      SR_RET_LO: rd_data = ret_lo;
      SR_RET_HI: rd_data = ret_hi;
      default:   rd_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_out   <= '0;
      sr_valid <= 1'b0;
      sr_err   <= 1'b0;
    end else if (sr_re) begin
      sr_out   <= rd_data;
      sr_valid <= 1'b1;
      sr_err   <= rd_err;
    end else begin
      // sr_out keeps the last read value between strobes.
      sr_valid <= 1'b0;
      sr_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sregs_rd.sv
// tb_sregs_rd: directed self-checking bench for sregs_rd. Inputs change 1 ns
// after each rising edge; outputs are sampled at that same point.
module tb_sregs_rd;
  import sregs_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sr_re;
  logic [SR_W-1:0] sr_sel;
  logic            boot_mode;
  logic            instr_mem_over;
  logic            instr_retire;
  logic            cnt_en;
  logic [SR_W-1:0] sr_out;
  logic            sr_valid;
  logic            sr_err;

  int tests = 0;
  int fails = 0;

  sregs_rd dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sr_re          (sr_re),
    .sr_sel         (sr_sel),
    .boot_mode      (boot_mode),
    .instr_mem_over (instr_mem_over),
    .instr_retire   (instr_retire),
    .cnt_en         (cnt_en),
    .sr_out         (sr_out),
    .sr_valid       (sr_valid),
    .sr_err         (sr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [15:0] sel);
    sr_re  = 1'b1;
    sr_sel = sel;
    step();
  endtask

  task automatic idle();
    sr_re = 1'b0;
    step();
  endtask

  task automatic check_rd(input string tag, input logic [15:0] data, input logic err);
    check({tag, ".out"},   sr_out,   data);
    check({tag, ".valid"}, sr_valid, 16'd1);
    check({tag, ".err"},   sr_err,   {15'd0, err});
  endtask

  initial begin
    rst_n          = 1'b0;
    sr_re          = 1'b0;
    sr_sel         = '0;
    boot_mode      = 1'b0;
    instr_mem_over = 1'b0;
    instr_retire   = 1'b0;
    cnt_en         = 1'b0;

    // Reset state
    #12;
    check("rst.out",   sr_out,   16'h0000);
    check("rst.valid", sr_valid, 16'd0);
    check("rst.err",   sr_err,   16'd0);
    rst_n = 1'b1;

    // ID read, then idle: valid drops, data holds
    rd(SR_ID);
    check_rd("id", 16'h0001, 1'b0);
    idle();
    check("id_idle.valid", sr_valid, 16'd0);
    check("id_idle.err",   sr_err,   16'd0);
    check("id_idle.hold",  sr_out,   16'h0001);

    // Mode reflection
    boot_mode = 1'b1; instr_mem_over = 1'b0;
    rd(SR_MODE);
    check_rd("mode10", 16'h0001, 1'b0);
    boot_mode = 1'b0; instr_mem_over = 1'b1;
    rd(SR_MODE);
    check_rd("mode01", 16'h0002, 1'b0);

    // Stale shadows straight after reset
    rd(SR_CYC_HI);
    check_rd("cyc_hi_stale", 16'h0000, 1'b0);
    rd(SR_RET_HI);
    check_rd("ret_hi_stale", 16'h0000, 1'b0);

    // Unmapped selectors, back to back
    rd(16'h0002);   // leave a nonzero-free baseline is not needed; 7 must force 0
    rd(16'h0007);
    check_rd("unmapped7", 16'h0000, 1'b1);
    rd(SR_ID);
    rd(16'hFFFF);
    check_rd("unmappedFFFF", 16'h0000, 1'b1);
    idle();
    check("unmapped_idle.valid", sr_valid, 16'd0);
    check("unmapped_idle.err",   sr_err,   16'd0);

    // Cycle counter: still 0 (cnt_en low so far). Count to 32'h0000_FFFF.
    cnt_en = 1'b1;
    sr_re  = 1'b0;
    repeat (65535) step();
    rd(SR_CYC_LO);                 // pre-increment FFFF; shadow takes 0000
    check_rd("cyc_lo_ffff", 16'hFFFF, 1'b0);
    cnt_en = 1'b0;                 // counter now frozen at 32'h0001_0000
    rd(SR_CYC_HI);
    check_rd("cyc_hi_precarry", 16'h0000, 1'b0);
    rd(SR_CYC_LO);
    check_rd("cyc_lo_10000", 16'h0000, 1'b0);
    rd(SR_CYC_HI);
    check_rd("cyc_hi_10000", 16'h0001, 1'b0);

    // Retired counter: 10 pulses interleaved with idle cycles (20 edges)
    sr_re  = 1'b0;
    cnt_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      instr_retire = 1'b1; step();
      instr_retire = 1'b0; step();
    end
    rd(SR_RET_LO);
    check_rd("ret_lo_10", 16'd10, 1'b0);
    rd(SR_RET_HI);
    check_rd("ret_hi_0", 16'h0000, 1'b0);
    // Cycle counter advanced 22 edges from 32'h0001_0000
    rd(SR_CYC_LO);
    check_rd("cyc_lo_after_ret", 16'h0016, 1'b0);
    rd(SR_CYC_HI);
    check_rd("cyc_hi_after_ret", 16'h0001, 1'b0);

    // Counting disabled: retire pulses ignored
    cnt_en = 1'b0;
    sr_re  = 1'b0;
    repeat (3) begin
      instr_retire = 1'b1; step();
    end
    instr_retire = 1'b0;
    rd(SR_RET_LO);
    check_rd("ret_lo_hold", 16'd10, 1'b0);

    // Mid-cycle reset with a read outstanding and another one requested
    rd(SR_ID);
    check_rd("pre_reset", 16'h0001, 1'b0);
    sr_sel = SR_MODE;              // sr_re still high: a pending read
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_async.out",   sr_out,   16'h0000);
    check("reset_async.valid", sr_valid, 16'd0);
    check("reset_async.err",   sr_err,   16'd0);
    step();                        // an edge inside reset: read is dropped
    check("reset_hold.valid", sr_valid, 16'd0);
    check("reset_hold.out",   sr_out,   16'h0000);
    #3;
    rst_n = 1'b1;
    sr_re = 1'b0;
    step();

    // Fresh data after release; counters and shadows cleared
    rd(SR_ID);
    check_rd("post_reset_id", 16'h0001, 1'b0);
    rd(SR_CYC_HI);
    check_rd("post_reset_cyc_hi", 16'h0000, 1'b0);
    rd(SR_CYC_LO);
    check_rd("post_reset_cyc_lo", 16'h0000, 1'b0);
    rd(SR_RET_LO);
    check_rd("post_reset_ret_lo", 16'h0000, 1'b0);
    idle();
    check("final_idle.valid", sr_valid, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sregs_rd.md
Name: sregs_rd

Overview:
- Read-side responder for the special-register interface; the counterpart of the write-side block that latches sr_in under sr_ie and sr_sel.
- Decodes sr_sel on a read strobe and returns a registered 16-bit value on sr_out with a valid flag.
- Owns two 32-bit performance counters, cycles and retired instructions. Each counter is read as two 16-bit halves through an atomic high-half snapshot.
- Reflects the live boot_mode and instr_mem_over control outputs back to software.

Parameters:
- CPU_ID, 16'h0001, constant returned at selector 0.
- CNT_W, 32, counter width; fixed at 32 (two 16-bit halves).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- sr_re  in  1  read strobe, one cycle per read
- sr_sel  in  16  special-register index (binary value)
- boot_mode  in  1  current boot mode, from write-side block
- instr_mem_over  in  1  current instruction-memory override, from write-side block
- instr_retire  in  1  one pulse per retired instruction
- cnt_en  in  1  counter enable; when 0 both counters hold
- sr_out  out  16  read data
- sr_valid  out  1  read data valid, single-cycle pulse
- sr_err  out  1  read of unmapped selector, single-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous): sr_out=0, sr_valid=0, sr_err=0, both counters=0, both shadows=0. Takes effect immediately, including mid-read; the pending read is dropped.
- Latency: sr_re sampled high at edge N gives sr_out/sr_valid at edge N. Data is visible for the cycle after N, i.e. one-cycle latency.
- Back-to-back reads every cycle are supported; each produces its own sr_valid pulse.
- sr_re low at edge: sr_valid=0, sr_err=0, sr_out holds its last value.
- Selector map on a read:
  - 0: CPU_ID
  - 1: {14'b0, instr_mem_over, boot_mode}
  - 2: cycle[15:0]; the same edge loads cyc_shadow <= cycle[31:16]
  - 3: cyc_shadow
  - 4: retired[15:0]; the same edge loads ret_shadow <= retired[31:16]
  - 5: ret_shadow
  - any other value: sr_out=0, sr_valid=1, sr_err=1
- Cycle counter: +1 every edge while cnt_en=1; wraps 32'hFFFFFFFF to 0 silently.
- Retired counter: +1 on each edge with instr_retire=1 and cnt_en=1; same wrap rule.
- Simultaneous read and increment: a read returns the pre-increment value, and the shadow captures the pre-increment high half. Low and high halves are therefore always coherent, including across a 16-bit carry.
- Reading selector 3 or 5 without a prior low read returns the stale shadow (0 after reset). This is defined behaviour, not an error.
- Shadows change only on low-half reads; counting never alters them.
- No write path. sr_ie traffic is owned by the write-side block and is ignored here.

Decomposition:
- Shared package sregs_pkg:
  - selector constants SR_ID=0, SR_MODE=1, SR_CYC_LO=2, SR_CYC_HI=3, SR_RET_LO=4, SR_RET_HI=5
  - CPU_ID default
  - the write-side selectors, so both ends share one map
- Sub-module snap_cnt32, instantiated twice (cycles, retired):
  - inputs: clk, rst_n, inc, snap
  - outputs: lo[15:0] (live), hi_shadow[15:0]
  - contains the 32-bit counter and its shadow register.
- Top level holds only selector decode and the output registers.

Test Plan:
- Reset then read sel 0 at cycle 1 -> next cycle sr_out=16'h0001, sr_valid=1, sr_err=0; following cycle sr_valid=0.
- Drive boot_mode=1, instr_mem_over=0, read sel 1 -> sr_out=16'h0001; flip to 0/1, read again -> 16'h0002.
- Force cycle to 32'h0000_FFFF, read sel 2 then sel 3 back-to-back -> sr_out=16'hFFFF then 16'h0000 (shadow taken pre-carry). Repeat one cycle later -> 16'h0000 then 16'h0001.
- cnt_en=1, 10 instr_retire pulses interleaved with idle cycles, read sel 4 then sel 5 -> 16'd10, 16'd0; with cnt_en=0, further pulses -> still 10.
- Read sel 16'h0007 and sel 16'hFFFF -> sr_out=0, sr_valid=1, sr_err=1 for one cycle each.
- Assert rst_n low mid-clock during an outstanding read -> sr_valid, sr_out and counters go to 0 before the next edge; the first read after release returns fresh data.
